tcor_bank: RTL

Parametrised multi-channel timer constant/compare register bank for the APB timer.
- Holds NUM_CH compare constants of DATA_WIDTH bits each.
- Compares each constant against the timer counter on every count tick.
- Produces a registered compare-match pulse and a sticky compare-match flag per channel.
- Sits between the APB register decode (write strobes, write data) and the counter/control logic (counter value, tick, overflow).

---
 rtl/tcor_pkg.sv | 13 +
 rtl/tcor_channel.sv | 97 +++++++++
 rtl/tcor_bank.sv | 41 ++++
 3 files changed

// File: rtl/tcor_pkg.sv
// rtl/tcor_pkg.sv - shared constants and channel state type for the timer constant/compare bank
package tcor_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_NUM_CH     = 2;
    localparam int MAX_NUM_CH         = 8;

    typedef enum logic {
        TCOR_IDLE    = 1'b0,
        TCOR_PENDING = 1'b1
    } tcor_state_e;

endpackage

// File: rtl/tcor_channel.sv
// rtl/tcor_channel.sv - one compare channel: constant register(s), compare, match pulse, sticky flag (TCOR_BUFFER_EN adds shadow)
module tcor_channel
    import tcor_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] SET_VALUE  = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic [DATA_WIDTH-1:0] cnt,
    input  logic                  cnt_en,
    input  logic                  ovf,
    input  logic                  flag_clr,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  cmp_match,
    output logic                  cmf
);

    logic [DATA_WIDTH-1:0] active;
    logic [DATA_WIDTH-1:0] active_next;
    logic                  hit;
    logic                  cmf_next;

    // Compare sees the pre-edge active value, so a same-cycle write or transfer never affects it.
    assign hit      = cnt_en && (cnt == active);
    assign cmf_next = hit | (cmf & ~flag_clr);
    assign dataout  = active;

`ifdef TCOR_BUFFER_EN
    tcor_state_e           state;
    tcor_state_e           state_next;
    logic [DATA_WIDTH-1:0] shadow;
    logic [DATA_WIDTH-1:0] shadow_next;

    always_comb begin
        state_next  = state;
        active_next = active;
        shadow_next = shadow;
        if (wren) begin
            shadow_next = datain;
        end
        case (state)
            TCOR_IDLE: begin
                if (wren) begin
                    state_next = TCOR_PENDING;
                end
            end
            TCOR_PENDING: begin
                // A write landing on the transfer edge re-arms: the old shadow goes live, the new one waits.
                if (ovf) begin
                    active_next = shadow;
                    if (!wren) begin
                        state_next = TCOR_IDLE;
                    end
                end
            end
            default: state_next = TCOR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= TCOR_IDLE;
            shadow <= SET_VALUE;
        end else begin
            state  <= state_next;
            shadow <= shadow_next;
        end
    end
`else
    logic unused_ovf;

    assign unused_ovf = ovf;

    always_comb begin
        active_next = active;
        if (wren) begin
            active_next = datain;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= SET_VALUE;
            cmp_match <= 1'b0;
            cmf       <= 1'b0;
        end else begin
            active    <= active_next;
            cmp_match <= hit;
            cmf       <= cmf_next;
        end
    end

endmodule

// File: rtl/tcor_bank.sv
// rtl/tcor_bank.sv - NUM_CH-channel timer constant/compare register bank (TCOR_BUFFER_EN selects double-buffered constants)
module tcor_bank
    import tcor_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int                    NUM_CH     = DEFAULT_NUM_CH,
    parameter logic [DATA_WIDTH-1:0] SET_VALUE  = '1
) (
    input  logic                         i_clk_sys,
    input  logic                         i_rst,
    input  logic [NUM_CH-1:0]            i_wren,
    input  logic [DATA_WIDTH-1:0]        i_datain,
    input  logic [DATA_WIDTH-1:0]        i_cnt,
    input  logic                         i_cnt_en,
    input  logic                         i_ovf,
    input  logic [NUM_CH-1:0]            i_flag_clr,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_dataout,
    output logic [NUM_CH-1:0]            o_cmp_match,
    output logic [NUM_CH-1:0]            o_cmf
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tcor_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .SET_VALUE  (SET_VALUE)
        ) u_ch (
            .clk       (i_clk_sys),
            .rst       (i_rst),
            .wren      (i_wren[k]),
            .datain    (i_datain),
            .cnt       (i_cnt),
            .cnt_en    (i_cnt_en),
            .ovf       (i_ovf),
            .flag_clr  (i_flag_clr[k]),
            .dataout   (o_dataout[k*DATA_WIDTH +: DATA_WIDTH]),
            .cmp_match (o_cmp_match[k]),
            .cmf       (o_cmf[k])
        );
    end

endmodule
